// File: rtl/adder_tree_feeder.sv
// adder_tree_feeder: serial-to-parallel front end for the floating-point AdderTree.
// It packs up to LENGTH words into tree_addends, pulses tree_valid_in for one cycle,
// waits for tree_valid_out, and returns the captured sum on a valid/ready stream.
// Optional macro FEEDER_TIMEOUT_EN adds a WAIT-state watchdog and a sticky timeout_err flag.
//
// Handshakes: a word moves on s_* in a cycle where s_valid && s_ready are both high at
// the rising edge. A sum moves on m_* in a cycle where m_valid && m_ready are both high.
// m_valid never drops and m_sum never changes until that handshake has happened.
module adder_tree_feeder #(
    parameter int DATA_WIDTH     = 32,
    parameter int LENGTH         = 18,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         s_valid,
    input  logic                         s_last,
    output logic                         s_ready,
    output logic [DATA_WIDTH*LENGTH-1:0] tree_addends,
    output logic                         tree_valid_in,
    input  logic [DATA_WIDTH-1:0]        tree_sum,
    input  logic                         tree_valid_out,
    output logic [DATA_WIDTH-1:0]        m_sum,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

    // Nonsensical configurations are rejected at elaboration time.
    if (LENGTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("adder_tree_feeder: LENGTH must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             group_done;
    logic             wait_expired;

    // A word is accepted only in FILL, and never while reset is held.
    assign accept     = s_valid && (state == FILL) && !rst;
    // The group closes on the LENGTH-th word, or earlier on s_last.
    assign group_done = accept && ((idx == LAST_IDX) || s_last);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the Moore-style handshake outputs.
    always_comb begin
        state_next    = state;
        s_ready       = 1'b0;
        tree_valid_in = 1'b0;
        busy          = 1'b1;
        case (state)
            FILL: begin
                s_ready = !rst;
                busy    = 1'b0;
                if (group_done) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                tree_valid_in = 1'b1;
                state_next    = WAIT;
            end
            WAIT: begin
                if (tree_valid_out) begin
                    state_next = OUT;
                end else if (wait_expired) begin
                    state_next = FILL;
                end
            end
            OUT: begin
                if (m_ready) begin
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    // Slot packing, sum capture and the output stream registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            tree_addends <= '0;
            m_sum        <= '0;
            m_valid      <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        // Unused upper slots become +0.0 so a short group sums correctly.
                        for (int j = 0; j < LENGTH; j++) begin
                            if (j == int'(idx)) begin
                                tree_addends[j*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                            end else if (group_done && (j > int'(idx))) begin
                                tree_addends[j*DATA_WIDTH +: DATA_WIDTH] <= '0;
                            end
                        end
                        if (group_done) begin
                            idx <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // Leaving WAIT on the same edge means only the first valid cycle captures.
                    if (tree_valid_out) begin
                        m_sum   <= tree_sum;
                        m_valid <= 1'b1;
                    end else if (wait_expired) begin
                        tree_addends <= '0;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid      <= 1'b0;
                        tree_addends <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef FEEDER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    // The last allowed WAIT cycle passing without a tree answer abandons the group.
    assign wait_expired = (state == WAIT) && !tree_valid_out && (wait_cnt == CNT_LAST);
    assign timeout_err  = timeout_q;

    // WAIT cycle counter (zeroed in ISSUE) and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (wait_expired) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign wait_expired = 1'b0;
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Directed bench for adder_tree_feeder; the tree is modelled by driving tree_valid_out/tree_sum by hand.
module tb_adder_tree_feeder;

    localparam int DW  = 32;
    localparam int LEN = 18;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [DW*LEN-1:0] tree_addends;
    logic              tree_valid_in;
    logic [DW-1:0]     tree_sum;
    logic              tree_valid_out;
    logic [DW-1:0]     m_sum;
    logic              m_valid;
    logic              m_ready;
    logic              busy;
    logic              timeout_err;

    int checks   = 0;
    int failures = 0;

    adder_tree_feeder #(
        .DATA_WIDTH    (DW),
        .LENGTH        (LEN),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .tree_addends  (tree_addends),
        .tree_valid_in (tree_valid_in),
        .tree_sum      (tree_sum),
        .tree_valid_out(tree_valid_out),
        .m_sum         (m_sum),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] slot(input int i);
        return tree_addends[i*DW +: DW];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_words(input int n, input logic [DW-1:0] d, input bit last_on_final);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = d;
            s_last  = last_on_final && (i == n - 1);
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    int pulses;
    int early;
    int bad;
    logic [DW-1:0] held;

    initial begin
        rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        tree_sum = '0; tree_valid_out = 1'b0; m_ready = 1'b0;

        // ---- reset state ----
        step();
        step();
        check("rst_s_ready", {31'b0, s_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("rst_valid_in", {31'b0, tree_valid_in}, 32'd0);
        check("rst_m_sum", m_sum, 32'd0);
        check("rst_timeout", {31'b0, timeout_err}, 32'd0);
        check("rst_slot0", slot(0), 32'd0);
        check("rst_slot17", slot(17), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_s_ready", {31'b0, s_ready}, 32'd1);

        // ---- full group of 18 x 1.0, tree answers 21 cycles after valid_in ----
        send_words(18, 32'h3F80_0000, 1'b0);
        check("g1_valid_in", {31'b0, tree_valid_in}, 32'd1);
        check("g1_issue_s_ready", {31'b0, s_ready}, 32'd0);
        check("g1_issue_busy", {31'b0, busy}, 32'd1);
        pulses = 1;
        early  = 0;
        for (int k = 1; k <= 21; k++) begin
            step();
            if (tree_valid_in) pulses++;
            if (m_valid) early++;
        end
        for (int i = 0; i < LEN; i++) check($sformatf("g1_slot%0d", i), slot(i), 32'h3F80_0000);
        tree_valid_out = 1'b1;
        tree_sum       = 32'h4190_0000;
        step();
        tree_valid_out = 1'b0;
        tree_sum       = '0;
        check("g1_pulses", pulses, 32'd1);
        check("g1_early_m_valid", early, 32'd0);
        check("g1_m_valid", {31'b0, m_valid}, 32'd1);
        check("g1_m_sum", m_sum, 32'h4190_0000);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("g1_post_m_valid", {31'b0, m_valid}, 32'd0);
        check("g1_post_s_ready", {31'b0, s_ready}, 32'd1);
        check("g1_post_busy", {31'b0, busy}, 32'd0);
        check("g1_post_slot0", slot(0), 32'd0);

        // ---- partial group: 5 x 2.0 with s_last, then backpressure ----
        send_words(5, 32'h4000_0000, 1'b1);
        check("g2_valid_in", {31'b0, tree_valid_in}, 32'd1);
        step();
        check("g2_wait_valid_in", {31'b0, tree_valid_in}, 32'd0);
        for (int i = 0; i < LEN; i++)
            check($sformatf("g2_slot%0d", i), slot(i), (i < 5) ? 32'h4000_0000 : 32'h0);
        tree_valid_out = 1'b1;
        tree_sum       = 32'h4120_0000;
        step();
        tree_valid_out = 1'b0;
        tree_sum       = '0;
        check("g2_m_valid", {31'b0, m_valid}, 32'd1);
        check("g2_m_sum", m_sum, 32'h4120_0000);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (m_sum !== 32'h4120_0000 || m_valid !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        check("g2_stall_stable", bad, 32'd0);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("g2_post_s_ready", {31'b0, s_ready}, 32'd1);
        check("g2_post_m_valid", {31'b0, m_valid}, 32'd0);

        // ---- stray tree_valid_out in FILL/ISSUE, long pulse in WAIT ----
        tree_valid_out = 1'b1;
        tree_sum       = 32'hDEAD_BEEF;
        step();
        tree_valid_out = 1'b0;
        check("g3_fill_ignore_m_valid", {31'b0, m_valid}, 32'd0);
        check("g3_fill_ignore_busy", {31'b0, busy}, 32'd0);
        send_words(3, 32'h3F80_0000, 1'b1);
        check("g3_valid_in", {31'b0, tree_valid_in}, 32'd1);
        tree_valid_out = 1'b1;
        tree_sum       = 32'hBAD0_BAD0;
        step();
        check("g3_issue_ignore", {31'b0, m_valid}, 32'd0);
        tree_sum = 32'h4040_0000;
        step();
        check("g3_m_valid", {31'b0, m_valid}, 32'd1);
        check("g3_m_sum_first", m_sum, 32'h4040_0000);
        tree_sum = 32'h1111_1111;
        step();
        check("g3_m_sum_hold1", m_sum, 32'h4040_0000);
        tree_sum = 32'h2222_2222;
        step();
        check("g3_m_sum_hold2", m_sum, 32'h4040_0000);
        tree_valid_out = 1'b0;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("g3_post_m_valid", {31'b0, m_valid}, 32'd0);
        step();
        check("g3_single_m_valid", {31'b0, m_valid}, 32'd0);

        // ---- reset during WAIT, stale answer, then a fresh group ----
        send_words(18, 32'h3F80_0000, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        check("g4_rst_s_ready", {31'b0, s_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("g4_busy", {31'b0, busy}, 32'd0);
        check("g4_valid_in", {31'b0, tree_valid_in}, 32'd0);
        check("g4_m_valid", {31'b0, m_valid}, 32'd0);
        check("g4_m_sum", m_sum, 32'd0);
        check("g4_slot0", slot(0), 32'd0);
        check("g4_slot17", slot(17), 32'd0);
        tree_valid_out = 1'b1;
        tree_sum       = 32'h0BAD_0BAD;
        step();
        tree_valid_out = 1'b0;
        check("g4_stale_m_valid", {31'b0, m_valid}, 32'd0);
        check("g4_stale_busy", {31'b0, busy}, 32'd0);
        send_words(18, 32'h4000_0000, 1'b0);
        check("g4_new_valid_in", {31'b0, tree_valid_in}, 32'd1);
        step();
        check("g4_new_slot0", slot(0), 32'h4000_0000);
        check("g4_new_slot17", slot(17), 32'h4000_0000);
        tree_valid_out = 1'b1;
        tree_sum       = 32'h4210_0000;
        step();
        tree_valid_out = 1'b0;
        check("g4_new_m_valid", {31'b0, m_valid}, 32'd1);
        check("g4_new_m_sum", m_sum, 32'h4210_0000);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("g4_new_post_busy", {31'b0, busy}, 32'd0);

        // ---- tree never answers ----
        send_words(2, 32'h3F80_0000, 1'b1);
        check("g5_valid_in", {31'b0, tree_valid_in}, 32'd1);
`ifdef FEEDER_TIMEOUT_EN
        step();
        for (int k = 0; k < 63; k++) step();
        check("g5_last_wait_busy", {31'b0, busy}, 32'd1);
        check("g5_last_wait_timeout", {31'b0, timeout_err}, 32'd0);
        step();
        check("g5_timeout", {31'b0, timeout_err}, 32'd1);
        check("g5_busy", {31'b0, busy}, 32'd0);
        check("g5_m_valid", {31'b0, m_valid}, 32'd0);
        check("g5_slot0", slot(0), 32'd0);
        step();
        step();
        check("g5_sticky", {31'b0, timeout_err}, 32'd1);
`else
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (busy !== 1'b1 || timeout_err !== 1'b0 || m_valid !== 1'b0) bad++;
        end
        check("g5_hold_wait", bad, 32'd0);
        check("g5_slot1", slot(1), 32'h3F80_0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
